// File: rtl/handshake_dst_sync.sv
// Destination side of a 4-phase req/ack crossing. It synchronizes sreq, captures
// sdata on acceptance and tags each accepted word with its position in the frame.
module handshake_dst_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_WORDS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sreq,
  input  logic [29:0] sdata,
  input  logic        busy,
  input  logic        frame_clr,
  output logic        dack,
  output logic        dvalid,
  output logic [29:0] dout,
  output logic [2:0]  word_idx,
  output logic        frame_done
);

  // state | meaning
  // IDLE  | waiting for req_s=1 with busy=0
  // ACK   | word captured, dack high until req_s returns to 0
  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  localparam logic [2:0] LAST_IDX = 3'(FRAME_WORDS - 1);

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   accept;
  logic [2:0]             idx_next;
  logic                   first_q;
  logic                   clr_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], sreq};
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_s && !busy) state_next = ACK;
      ACK:     if (!req_s)         state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  always_comb begin
    accept   = (state == IDLE) && req_s && !busy;
    idx_next = word_idx + 3'd1;
    // A clear arriving on the accepting edge itself still restarts the frame.
    if (first_q || clr_pend || frame_clr || (word_idx == LAST_IDX))
      idx_next = 3'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dack       <= 1'b0;
      dvalid     <= 1'b0;
      frame_done <= 1'b0;
      dout       <= 30'h0;
      word_idx   <= 3'd0;
      first_q    <= 1'b1;
      clr_pend   <= 1'b0;
    end else begin
      dack       <= (state_next == ACK);
      dvalid     <= accept;
      frame_done <= accept && (idx_next == LAST_IDX);
      if (accept) begin
        dout     <= sdata;
        word_idx <= idx_next;
        first_q  <= 1'b0;
        clr_pend <= 1'b0;
      end else if (frame_clr) begin
        clr_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_handshake_dst_sync.sv
// Bench for handshake_dst_sync: a source model drives 4-phase transfers, a queue
// scoreboard holds expected words and a negedge monitor checks every dvalid.
module tb_handshake_dst_sync;

  localparam int FW = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sreq;
  logic [29:0] sdata;
  logic        busy;
  logic        frame_clr;
  logic        dack;
  logic        dvalid;
  logic [29:0] dout;
  logic [2:0]  word_idx;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int model_idx = 0;
  bit busy_rand = 0;
  bit prev_dv = 0;

  logic [29:0] q_data[$];
  logic [2:0]  q_idx[$];
  logic        q_fd[$];

  handshake_dst_sync #(.SYNC_STAGES(2), .FRAME_WORDS(FW)) dut (
    .clk(clk), .rst_n(rst_n), .sreq(sreq), .sdata(sdata), .busy(busy),
    .frame_clr(frame_clr), .dack(dack), .dvalid(dvalid), .dout(dout),
    .word_idx(word_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word n of a frame carries index n mod FW.
  task automatic push(input logic [29:0] d);
    q_data.push_back(d);
    q_idx.push_back(3'(model_idx));
    q_fd.push_back(model_idx == FW - 1);
    model_idx = (model_idx + 1) % FW;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && dvalid) begin
        chk("dvalid_back_to_back", 32'(prev_dv), 32'd0);
        if (q_data.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_dvalid: got dout=%0h expected no word", dout);
        end else begin
          chk("dout", 32'(dout), 32'(q_data.pop_front()));
          chk("word_idx", 32'(word_idx), 32'(q_idx.pop_front()));
          chk("frame_done", 32'(frame_done), 32'(q_fd.pop_front()));
        end
      end else if (rst_n && frame_done) begin
        chk("frame_done_without_dvalid", 32'(frame_done), 32'd0);
      end
      prev_dv = dvalid;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (busy_rand) busy = ($urandom_range(0, 9) < 3);
    end
  end

  task automatic wait_dack(input logic lvl, input string name);
    int n = 0;
    while (dack !== lvl && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(dack), 32'(lvl));
  endtask

  task automatic send(input logic [29:0] d);
    wait_dack(1'b0, "idle_before_send");
    sdata = d;
    sreq  = 1'b1;
    push(d);
    wait_dack(1'b1, "ack_rise");
    repeat ($urandom_range(0, 2)) @(negedge clk);
    sreq = 1'b0;
    wait_dack(1'b0, "ack_fall");
  endtask

  task automatic pulse_clr();
    frame_clr = 1'b1;
    @(negedge clk);
    frame_clr = 1'b0;
    model_idx = 0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; sreq = 1'b0; sdata = 30'h0; busy = 1'b0; frame_clr = 1'b0;
    #1;
    chk("rst_dack", 32'(dack), 32'd0);
    chk("rst_dvalid", 32'(dvalid), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_word_idx", 32'(word_idx), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word: latency and dack release timing
    sdata = 30'h2AAAA555;
    sreq  = 1'b1;
    push(30'h2AAAA555);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dvalid && n < 20);
    chk("first_latency", 32'(n), 32'd3);
    chk("dack_with_dvalid", 32'(dack), 32'd1);
    sreq = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("dack_hold_after_drop", 32'(dack), 32'd1);
    end
    @(negedge clk);
    chk("dack_release", 32'(dack), 32'd0);

    // Full frame plus wrap
    pulse_clr();
    for (int i = 1; i <= 7; i++) send(30'(i));

    // frame_clr between words
    pulse_clr();
    for (int i = 0; i < 3; i++) send(30'h100 + 30'(i));
    pulse_clr();
    chk("idx_hold_on_clr", 32'(word_idx), 32'd2);
    send(30'h200);

    // busy stall, then acceptance coincident with frame_clr
    busy  = 1'b1;
    sdata = 30'h155;
    sreq  = 1'b1;
    model_idx = 0;
    push(30'h155);
    repeat (10) begin
      @(negedge clk);
      chk("busy_no_dvalid", 32'(dvalid), 32'd0);
      chk("busy_no_dack", 32'(dack), 32'd0);
    end
    busy = 1'b0;
    frame_clr = 1'b1;
    @(negedge clk);
    frame_clr = 1'b0;
    chk("accept_after_busy", 32'(dvalid), 32'd1);
    sreq = 1'b0;
    wait_dack(1'b0, "ack_fall_busy");
    send(30'h156);

    // Reset during ACK with sreq still high
    sdata = 30'h3C3C3C3;
    sreq  = 1'b1;
    push(30'h3C3C3C3);
    wait_dack(1'b1, "ack_before_reset");
    rst_n = 1'b0;
    #1;
    chk("reset_drops_dack", 32'(dack), 32'd0);
    chk("reset_word_idx", 32'(word_idx), 32'd0);
    model_idx = 0;
    push(30'h3C3C3C3);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dvalid && n < 20);
    chk("reaccept_latency", 32'(n), 32'd3);
    sreq = 1'b0;
    wait_dack(1'b0, "ack_fall_reset");

    // Random traffic with random stalls
    busy_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(30'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    busy_rand = 1'b0;
    @(negedge clk);
    busy = 1'b0;
    repeat (10) @(negedge clk);
    chk("scoreboard_empty", 32'(q_data.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/handshake_dst_sync.md
HANDSHAKE_DST_SYNC -- requirements
Module: handshake_dst_sync

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops on sreq (legal range 2-3).
REQ-002 Parameter FRAME_WORDS, default 6, SHALL set the number of accepted words per frame (legal range 2-7).
REQ-003 clk  input  1  destination-domain clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sreq  input  1  request level from the source domain; asynchronous to clk.
REQ-006 sdata  input  30  payload {row[17:0], kernel[11:0]}; the source holds it stable while sreq=1 or dack=1.
REQ-007 busy  input  1  downstream stall; 1 blocks acceptance of a new word.
REQ-008 frame_clr  input  1  synchronous soft clear of the frame word index.
REQ-009 dack  output  1  acknowledge level returned to the source domain; driven directly from a flop.
REQ-010 dvalid  output  1  single-cycle pulse marking a new word on dout.
REQ-011 dout  output  30  captured payload; holds its value until the next acceptance.
REQ-012 word_idx  output  3  index (0..FRAME_WORDS-1) of the word currently on dout.
REQ-013 frame_done  output  1  pulse coincident with dvalid of the last word in a frame.

Function
REQ-014 Protocol SHALL be 4-phase: source raises sreq, destination accepts and raises dack, source drops sreq, destination drops dack.
REQ-015 sreq SHALL pass through a SYNC_STAGES flop chain; the last stage output is req_s. No other logic SHALL use raw sreq.
REQ-016 sdata SHALL be sampled only on the accepting edge, gated by req_s=1; it SHALL NOT pass through a synchronizer.
REQ-017 FSM states: IDLE, ACK.
REQ-018 IDLE -> ACK when req_s=1 and busy=0. On that edge: dout<=sdata, dack<=1, dvalid<=1 for one cycle, word_idx updated.
REQ-019 IDLE with req_s=1 and busy=1: no capture, dack stays 0, dvalid stays 0. Acceptance SHALL occur on the first edge where busy=0.
REQ-020 ACK -> IDLE when req_s=0; dack<=0 on that edge.
REQ-021 In ACK, busy SHALL be ignored and no second capture SHALL occur while req_s=1.
REQ-022 Latency with SYNC_STAGES=2 and busy=0: sreq first sampled high at edge E0; dvalid, dack and dout valid after edge E2. Total is SYNC_STAGES+1 edges.
REQ-023 Minimum period between two dvalid pulses SHALL be 2*SYNC_STAGES+2 clk cycles plus the source-side delay.
REQ-024 word_idx after acceptance SHALL be: 0 for the first word after reset or frame_clr, else previous+1.
REQ-025 word_idx SHALL wrap from FRAME_WORDS-1 to 0.
REQ-026 frame_done SHALL be 1 exactly when dvalid=1 and word_idx=FRAME_WORDS-1.
REQ-027 frame_clr without acceptance: the next accepted word SHALL get index 0. word_idx output is unchanged until that acceptance.
REQ-028 frame_clr on the same edge as acceptance: the accepted word SHALL get index 0. The following word SHALL get index 1.
REQ-029 dvalid and frame_done SHALL be registered outputs. Every output SHALL be glitch-free.

Reset
REQ-030 On rst_n=0, all of the following SHALL clear immediately:
- synchronizer chain and req_s: 0
- state: IDLE
- dack, dvalid, frame_done: 0
- dout: 30'h0, word_idx: 0
- pending frame_clr: cleared
REQ-031 Reset mid-transfer (state ACK) SHALL drop dack to 0 immediately and discard the transfer.
REQ-032 After reset release with sreq still 1, the word SHALL be re-accepted as a new word with index 0.

Verification
REQ-033 Single word, busy=0, sdata=30'h2AAAA555: dvalid pulses once, 3 edges after sreq sampled high; dout=30'h2AAAA555; dack=1 until 2 edges after sreq falls.
REQ-034 Frame of 6 words, data 1..6: word_idx sequence 0,1,2,3,4,5; frame_done=1 only with word 6; a 7th word gets word_idx=0.
REQ-035 busy=1 held 10 cycles while sreq=1: no dvalid and dack=0 throughout; busy falls -> dvalid on the next edge.
REQ-036 frame_clr pulsed after word 3 (idx 2): next word gets idx 0. frame_clr coincident with accept: idx 0, then 1.
REQ-037 rst_n asserted while dack=1 with sreq=1: dack=0 at once. On release, word re-accepted after 3 edges with idx 0.
REQ-038 Random sreq/busy traffic against a source model, 1000 words: no duplicate or lost words; dout matches sent order; dvalid never high on consecutive cycles.
